// File: rtl/multi_lane_ex_stage_if.sv
// rtl/multi_lane_ex_stage_if.sv - ID-to-EX-to-MEM handshake and payload bundle for the multi-lane EX stage
interface multi_lane_ex_stage_if #(
  parameter int LANES  = 2,
  parameter int LANE_W = 64
);
  logic                    next_allowin_i;
  logic [LANES-1:0]        pre_to_now_valid_i;
  logic [LANES-1:0]        pre_mc_i;
  logic [LANES*LANE_W-1:0] pre_to_ibus;
  logic                    excep_flush_i;
  logic                    now_allowin_o;
  logic [LANES-1:0]        now_to_next_valid_o;
  logic [LANES*LANE_W-1:0] to_next_obus;
  logic [LANES-1:0]        fwd_valid_o;
  logic [LANES-1:0]        fwd_ready_o;

  modport master (
    output next_allowin_i, pre_to_now_valid_i, pre_mc_i, pre_to_ibus, excep_flush_i,
    input  now_allowin_o, now_to_next_valid_o, to_next_obus, fwd_valid_o, fwd_ready_o
  );

  modport slave (
    input  next_allowin_i, pre_to_now_valid_i, pre_mc_i, pre_to_ibus, excep_flush_i,
    output now_allowin_o, now_to_next_valid_o, to_next_obus, fwd_valid_o, fwd_ready_o
  );
endinterface

// File: rtl/multi_lane_ex_stage.sv
// rtl/multi_lane_ex_stage.sv - lock-stepped N-lane EX pipeline register with multi-cycle occupancy; optional EX_STAGE_PERF_CNT_EN stall counter
module multi_lane_ex_stage #(
  parameter int LANES     = 2,
  parameter int LANE_W    = 64,
  parameter int MC_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_lane_ex_stage_if.slave  ex
`ifdef EX_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles_o
`endif
);

  // rst_n is active-high here: 1 means reset.
  localparam int CNT_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

  logic [LANES-1:0]        lane_valid;
  logic [LANES*LANE_W-1:0] lane_bus;
  logic [CNT_W-1:0]        lane_cnt [LANES];
  logic [LANES-1:0]        lane_ready;
  logic [LANES-1:0]        lane_done;
  logic                    ready_go;
  logic                    allowin;

  // Per-lane readiness; invalid lanes never hold the group back.
  always_comb begin
    lane_ready = '0;
    lane_done  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_done[i]  = (lane_cnt[i] == '0);
      lane_ready[i] = !lane_valid[i] || lane_done[i];
    end
  end

  assign ready_go = &lane_ready;
  assign allowin  = !(|lane_valid) || (ready_go && ex.next_allowin_i);

  // Handshake and forwarding outputs; payload comes straight from the registers.
  always_comb begin
    ex.now_allowin_o       = allowin;
    ex.now_to_next_valid_o = lane_valid & {LANES{ready_go && !ex.excep_flush_i}};
    ex.to_next_obus        = lane_bus;
    ex.fwd_valid_o         = lane_valid;
    ex.fwd_ready_o         = lane_valid & lane_done;
  end

  // Lane state: reset, then flush, then load, otherwise count down multi-cycle ops.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      lane_valid <= '0;
      lane_bus   <= '0;
      for (int i = 0; i < LANES; i++) lane_cnt[i] <= '0;
    end else if (ex.excep_flush_i) begin
      lane_valid <= '0;
      for (int i = 0; i < LANES; i++) lane_cnt[i] <= '0;
    end else if (allowin) begin
      lane_valid <= ex.pre_to_now_valid_i;
      lane_bus   <= ex.pre_to_ibus;
      for (int i = 0; i < LANES; i++)
        lane_cnt[i] <= (ex.pre_to_now_valid_i[i] && ex.pre_mc_i[i]) ? CNT_W'(MC_CYCLES - 1) : '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (lane_cnt[i] != '0) lane_cnt[i] <= lane_cnt[i] - CNT_W'(1);
    end
  end

`ifdef EX_STAGE_PERF_CNT_EN
  // Saturating count of cycles an occupied stage refuses a new group; flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst_n)
      stall_cycles_o <= '0;
    else if (|lane_valid && !allowin && stall_cycles_o != 32'hFFFF_FFFF)
      stall_cycles_o <= stall_cycles_o + 32'd1;
  end
`endif

endmodule
